// File: rtl/mux8way_rr_gather_pkg.sv
// Shared constants and state encoding for the 8-way round-robin gather.
// Imported by the picker and the top.
package mux8way_rr_gather_pkg;

    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/mux8way_rr_gather_rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping through 7 back to 0.
module rr_pick8
    import mux8way_rr_gather_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   gidx,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Scan from ptr upward modulo 8; keep the first hit.
    always_comb begin
        gidx = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = ptr + k[SEL_W-1:0];
            if (!any && req[idx]) begin
                any  = 1'b1;
                gidx = idx;
            end
        end
        grant = any ? (8'b1 << gidx) : '0;
    end

endmodule

// File: rtl/mux8way_rr_gather.sv
// Gathers eight valid/ready sources into one registered sink stream,
// tagging each beat with its source index; optional packet lock.
module mux8way_rr_gather
    import mux8way_rr_gather_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PKT_MODE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_valid,
    input  logic [8*WIDTH-1:0]     in_data,
    input  logic [7:0]             in_last,
    output logic [7:0]             in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [2:0]             out_sel,
    input  logic                   out_ready
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] lock_q, lock_d;

    logic [7:0]       req;
    logic [7:0]       grant;
    logic [SEL_W-1:0] gidx;
    logic             any;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;

    // While locked, only the packet owner may compete.
    always_comb begin
        req = in_valid;
        if (state_q == ST_LOCK) begin
            req = in_valid & (8'b1 << lock_q);
        end
    end

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    assign load     = !out_valid || out_ready;
    assign xfer     = load && any && !reset;
    assign in_ready = xfer ? grant : 8'h00;

    // Select the granted source's data and last flag.
    always_comb begin
        beat_data = '0;
        beat_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx == i[SEL_W-1:0]) begin
                beat_data = in_data[i*WIDTH +: WIDTH];
                beat_last = in_last[i];
            end
        end
    end

    // Next pointer, lock owner and state; lock only exists in packet mode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (xfer) begin
            if (state_q == ST_ARB || beat_last) begin
                ptr_d = gidx + 3'd1;
            end
            if (PKT_MODE != 0) begin
                unique case (state_q)
                    ST_ARB: begin
                        if (!beat_last) begin
                            state_d = ST_LOCK;
                            lock_d  = gidx;
                        end
                    end
                    ST_LOCK: begin
                        if (beat_last) begin
                            state_d = ST_ARB;
                        end
                    end
                    default: state_d = ST_ARB;
                endcase
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    // Output stage: refill or drain whenever the sink side allows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= beat_data;
                out_last <= beat_last;
                out_sel  <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_mux8way_rr_gather.sv
// Directed bench for mux8way_rr_gather: beat-mode instance and
// packet-mode instance driven side by side.
module tb_mux8way_rr_gather;

    logic        clock = 1'b0;
    logic        reset;

    logic [7:0]  in_valid, in_last, in_ready;
    logic [63:0] in_data;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;

    logic [7:0]  p_in_valid, p_in_last, p_in_ready;
    logic [63:0] p_in_data;
    logic        p_out_valid, p_out_last, p_out_ready;
    logic [7:0]  p_out_data;
    logic [2:0]  p_out_sel;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mux8way_rr_gather #(.WIDTH(8), .PKT_MODE(0)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    mux8way_rr_gather #(.WIDTH(8), .PKT_MODE(1)) u_pkt (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (p_in_valid),
        .in_data   (p_in_data),
        .in_last   (p_in_last),
        .in_ready  (p_in_ready),
        .out_valid (p_out_valid),
        .out_data  (p_out_data),
        .out_last  (p_out_last),
        .out_sel   (p_out_sel),
        .out_ready (p_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 8'hFF;
        in_last     = 8'h00;
        out_ready   = 1'b1;
        p_in_valid  = 8'h00;
        p_in_last   = 8'h00;
        p_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data[i*8 +: 8]   = 8'h10 + 8'(i);
            p_in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        end
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_ready", 32'(in_ready), 32'h00);

        reset    = 1'b0;
        in_valid = 8'h01;
        #1;
        check("first_ready", 32'(in_ready), 32'h01);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_sel", 32'(out_sel), 32'd0);
        check("first_data", 32'(out_data), 32'h10);

        in_valid = 8'hFF;
        tick();
        check("pre_sel1", 32'(out_sel), 32'd1);
        tick();
        check("pre_sel2", 32'(out_sel), 32'd2);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'h00);
        check("midrst_data", 32'(out_data), 32'h00);
        tick();
        reset = 1'b0;

        for (int k = 0; k < 9; k++) begin
            tick();
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_sel", 32'(out_sel), 32'(k % 8));
            check("fair_data", 32'(out_data), 32'(8'h10 + 8'(k % 8)));
        end

        in_valid = 8'h40;
        tick();
        check("wrap_pre", 32'(out_sel), 32'd6);
        in_valid = 8'h81;
        tick();
        check("wrap_7", 32'(out_sel), 32'd7);
        tick();
        check("wrap_0", 32'(out_sel), 32'd0);
        in_valid = 8'h80;
        tick();
        check("wrap_only7", 32'(out_sel), 32'd7);
        check("wrap_only7_d", 32'(out_data), 32'h17);

        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'h00);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sel", 32'(out_sel), 32'd7);
            check("bp_data", 32'(out_data), 32'h17);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", 32'(in_ready), 32'h01);
        tick();
        check("bp_next_sel", 32'(out_sel), 32'd0);
        check("bp_next_data", 32'(out_data), 32'h10);

        in_valid = 8'h00;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        p_in_valid = 8'h24;
        p_in_last  = 8'h00;
        #1;
        check("pkt_g1", 32'(p_in_ready), 32'h04);
        tick();
        check("pkt_b1", 32'(p_out_sel), 32'd2);
        check("pkt_b1_last", 32'(p_out_last), 32'd0);
        check("pkt_g2", 32'(p_in_ready), 32'h04);
        tick();
        check("pkt_b2", 32'(p_out_sel), 32'd2);
        p_in_last = 8'h04;
        #1;
        check("pkt_g3", 32'(p_in_ready), 32'h04);
        tick();
        check("pkt_b3", 32'(p_out_sel), 32'd2);
        check("pkt_b3_last", 32'(p_out_last), 32'd1);
        check("pkt_b3_data", 32'(p_out_data), 32'hA2);
        p_in_last = 8'h20;
        tick();
        check("pkt_src5", 32'(p_out_sel), 32'd5);
        check("pkt_src5_d", 32'(p_out_data), 32'hA5);

        p_in_valid = 8'h08;
        p_in_last  = 8'h00;
        tick();
        check("lock_b1", 32'(p_out_sel), 32'd3);
        p_in_valid = 8'h10;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lock_idle_rdy", 32'(p_in_ready), 32'h00);
            tick();
            check("lock_idle_vld", 32'(p_out_valid), 32'd0);
        end
        p_in_valid = 8'h18;
        p_in_last  = 8'h08;
        #1;
        check("lock_resume", 32'(p_in_ready), 32'h08);
        tick();
        check("lock_b2", 32'(p_out_sel), 32'd3);
        check("lock_b2_last", 32'(p_out_last), 32'd1);
        p_in_valid = 8'h10;
        p_in_last  = 8'h10;
        tick();
        check("unlock_src4", 32'(p_out_sel), 32'd4);
        check("unlock_vld", 32'(p_out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
